// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus for the fetch stage.
//   imem_req    : fetch request valid (driven by fetch stage)
//   imem_addr   : word-aligned fetch address (driven by fetch stage)
//   imem_ready  : rdata valid this cycle (driven by memory)
//   imem_rdata  : fetched instruction word (driven by memory)
// master = fetch stage side, slave = instruction memory side.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, requests instruction words over a req/ready bus, holds one
// returned instruction while decode is stalled, and discards the in-flight
// wrong-path fetch after a redirect.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   stall                : hazard unit holds IF/ID
//   redirect             : downstream branch/jump taken (flush)
//   redirect_target      : new PC on redirect (low two bits ignored)
//   imem                 : instruction memory bus (master side)
//   ifid_wrenable        : IF/ID write enable
//   ifid_instruction     : IF/ID instruction input
//   ifid_pc              : IF/ID PC input (fetched address + 4, 0 for bubbles)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  fetch_stage_if.master      imem,
  output logic               ifid_wrenable,
  output logic [31:0]        ifid_instruction,
  output logic [31:0]        ifid_pc
);

  // FETCH: normal operation. DROP: waiting out a wrong-path request.
  typedef enum logic [0:0] {FETCH = 1'b0, DROP = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] drop_addr_r, drop_addr_s;
  logic        buf_valid_r, buf_valid_s;
  logic [31:0] buf_instr_r, buf_instr_s;
  logic [31:0] buf_pc_r, buf_pc_s;

  logic        req_s;
  logic        accept_s;
  logic [31:0] addr_s;
  logic [31:0] pc_plus4_s;

  // Request generation: in DROP the abandoned address is re-presented until
  // memory completes it; in FETCH we stop requesting only when the buffer
  // is already occupied and decode cannot take anything.
  always_comb begin
    pc_plus4_s = pc_r + 32'd4;
    case (state_r)
      DROP: begin
        addr_s = drop_addr_r;
        req_s  = rst_n;
      end
      FETCH: begin
        addr_s = pc_r;
        req_s  = rst_n & (!buf_valid_r | !stall);
      end
      default: begin
        addr_s = pc_r;
        req_s  = 1'b0;
      end
    endcase
    accept_s = req_s & imem.imem_ready & (state_r == FETCH);
  end

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = addr_s;

  // IF/ID drive: reset and redirect force a written bubble; stall blocks the
  // write; otherwise the buffer has priority over fresh memory data.
  always_comb begin
    ifid_wrenable    = 1'b1;
    ifid_instruction = NOP_INSTR;
    ifid_pc          = 32'h0000_0000;
    if (!rst_n || redirect) begin
      ifid_wrenable = 1'b1;
    end else if (stall) begin
      ifid_wrenable = 1'b0;
    end else if (buf_valid_r) begin
      ifid_instruction = buf_instr_r;
      ifid_pc          = buf_pc_r;
    end else if (accept_s) begin
      ifid_instruction = imem.imem_rdata;
      ifid_pc          = pc_plus4_s;
    end else begin
      ifid_instruction = NOP_INSTR;
    end
  end

  // Next-state logic for PC, FSM and the one-entry buffer.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    drop_addr_s = drop_addr_r;
    buf_valid_s = buf_valid_r;
    buf_instr_s = buf_instr_r;
    buf_pc_s    = buf_pc_r;
    if (redirect) begin
      pc_s        = {redirect_target[31:2], 2'b00};
      buf_valid_s = 1'b0;
      // Memory still owes us a word for the current request: remember its
      // address so the request stays stable until it completes. In DROP this
      // keeps drop_addr unchanged.
      if (req_s && !imem.imem_ready) begin
        drop_addr_s = addr_s;
        state_s     = DROP;
      end else begin
        state_s = FETCH;
      end
    end else if (state_r == DROP) begin
      if (imem.imem_ready) begin
        state_s = FETCH;
      end else begin
        state_s = DROP;
      end
    end else begin
      if (accept_s) begin
        pc_s = pc_plus4_s;
      end else begin
        pc_s = pc_r;
      end
      if (stall) begin
        // req is low when the buffer is full, so accept implies empty buffer
        if (accept_s) begin
          buf_valid_s = 1'b1;
          buf_instr_s = imem.imem_rdata;
          buf_pc_s    = pc_plus4_s;
        end else begin
          buf_valid_s = buf_valid_r;
        end
      end else if (buf_valid_r) begin
        // Buffer drains to IF/ID; a same-cycle accept takes its place.
        if (accept_s) begin
          buf_valid_s = 1'b1;
          buf_instr_s = imem.imem_rdata;
          buf_pc_s    = pc_plus4_s;
        end else begin
          buf_valid_s = 1'b0;
        end
      end else begin
        buf_valid_s = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= FETCH;
      pc_r        <= RESET_PC;
      drop_addr_r <= 32'h0000_0000;
      buf_valid_r <= 1'b0;
      buf_instr_r <= 32'h0000_0000;
      buf_pc_r    <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      drop_addr_r <= drop_addr_s;
      buf_valid_r <= buf_valid_s;
      buf_instr_r <= buf_instr_s;
      buf_pc_r    <= buf_pc_s;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed cycle table, a hand-written wait-state
// sequence, and a randomized run checked against an instruction-stream model
// (every fetched word must reach IF/ID exactly once, in address order,
// restarting at each redirect target).
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        ifid_wrenable;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .imem             (bus.master),
    .ifid_wrenable    (ifid_wrenable),
    .ifid_instruction (ifid_instruction),
    .ifid_pc          (ifid_pc)
  );

  // Memory content: each word is its address xored with a fixed pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst_n, stall, redirect, ready;
    logic [31:0] target;
    logic        exp_req;
    logic        chk_addr;
    logic [31:0] exp_addr;
    logic        exp_wren;
    logic        chk_data;
    logic [31:0] exp_instr, exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic rd, input logic rdy,
                     input logic [31:0] tgt, input logic ereq, input logic ca,
                     input logic [31:0] ea, input logic ew, input logic cd,
                     input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.rst_n = r; v.stall = s; v.redirect = rd; v.ready = rdy; v.target = tgt;
    v.exp_req = ereq; v.chk_addr = ca; v.exp_addr = ea; v.exp_wren = ew;
    v.chk_data = cd; v.exp_instr = ei; v.exp_pc = ep;
    vecs.push_back(v);
  endtask

  // Apply inputs at the falling edge and let combinational outputs settle.
  task automatic drive(input logic r, input logic s, input logic rd, input logic rdy,
                       input logic [31:0] tgt);
    @(negedge clk);
    rst_n = r; stall = s; redirect = rd; bus.imem_ready = rdy; redirect_target = tgt;
    #1;
  endtask

  logic [31:0] exp_next;
  logic        prev_hold;
  logic [31:0] prev_addr;
  int          n_valid;
  logic        r_s, s_s, rd_s, rdy_s;
  logic [31:0] tgt_s;

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0000_0000;
    bus.imem_ready = 1'b0;

    //   rst st rd rdy target        req ca addr          wr cd instr          pc
    add(1'b0,1'b0,1'b0,1'b1,32'h0,         1'b0,1'b0,32'h0,         1'b1,1'b1,32'h0,         32'h0);
    add(1'b0,1'b0,1'b0,1'b1,32'h0,         1'b0,1'b1,32'h0,         1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h0,         1'b1,1'b1,32'hA5A5_0000,32'h4);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h4,         1'b1,1'b1,32'hA5A5_0004,32'h8);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h8,         1'b1,1'b1,32'hA5A5_0008,32'hC);
    add(1'b1,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,32'hC,         1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,32'hC,         1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'hC,         1'b1,1'b1,32'hA5A5_000C,32'h10);
    // stall at pc 0x10: word buffered, request withdrawn while buffered
    add(1'b1,1'b1,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h10,        1'b0,1'b0,32'h0,         32'h0);
    add(1'b1,1'b1,1'b0,1'b1,32'h0,         1'b0,1'b1,32'h14,        1'b0,1'b0,32'h0,         32'h0);
    add(1'b1,1'b1,1'b0,1'b1,32'h0,         1'b0,1'b1,32'h14,        1'b0,1'b0,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h14,        1'b1,1'b1,32'hA5A5_0010,32'h14);
    add(1'b1,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,32'h18,        1'b1,1'b1,32'hA5A5_0014,32'h18);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h18,        1'b1,1'b1,32'hA5A5_0018,32'h1C);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h1C,        1'b1,1'b1,32'hA5A5_001C,32'h20);
    // redirect to 0x40 while fetch of 0x20 is outstanding
    add(1'b1,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,32'h20,        1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b1,1'b0,32'h40,        1'b1,1'b1,32'h20,        1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,32'h20,        1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h20,        1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h40,        1'b1,1'b1,32'hA5A5_0040,32'h44);
    // redirect + stall with buffer full; target low bits ignored
    add(1'b1,1'b1,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h44,        1'b0,1'b0,32'h0,         32'h0);
    add(1'b1,1'b1,1'b1,1'b1,32'h83,        1'b0,1'b1,32'h48,        1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h80,        1'b1,1'b1,32'hA5A5_0080,32'h84);
    // reset while stalled with buffer full
    add(1'b1,1'b1,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h84,        1'b0,1'b0,32'h0,         32'h0);
    add(1'b0,1'b1,1'b0,1'b1,32'h0,         1'b0,1'b0,32'h0,         1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h0,         1'b1,1'b1,32'hA5A5_0000,32'h4);
    // reset while in DROP
    add(1'b1,1'b0,1'b1,1'b0,32'h100,       1'b1,1'b1,32'h4,         1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,32'h4,         1'b1,1'b1,32'h0,         32'h0);
    add(1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b1,32'h0,         1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h0,         1'b1,1'b1,32'hA5A5_0000,32'h4);
    // PC wrap: redirect to last word (ready in redirect cycle discarded)
    add(1'b1,1'b0,1'b1,1'b1,32'hFFFF_FFFF, 1'b1,1'b1,32'h4,         1'b1,1'b1,32'h0,         32'h0);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'hFFFF_FFFC, 1'b1,1'b1,32'h5A5A_FFFC,32'h0);
    add(1'b1,1'b0,1'b0,1'b1,32'h0,         1'b1,1'b1,32'h0,         1'b1,1'b1,32'hA5A5_0000,32'h4);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].redirect, vecs[i].ready, vecs[i].target);
      check($sformatf("vec%0d req", i), {31'd0, bus.imem_req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].chk_addr) check($sformatf("vec%0d addr", i), bus.imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d wren", i), {31'd0, ifid_wrenable}, {31'd0, vecs[i].exp_wren});
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d instr", i), ifid_instruction, vecs[i].exp_instr);
        check($sformatf("vec%0d pc", i), ifid_pc, vecs[i].exp_pc);
      end
    end

    // Two-wait-state memory: address held 3 cycles, two bubbles, then the word.
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 3; w++) begin
        drive(1'b1, 1'b0, 1'b0, (w == 2), 32'h0);
        check($sformatf("ws%0d.%0d addr", k, w), bus.imem_addr, 32'h4 + 32'(4 * k));
        check($sformatf("ws%0d.%0d req", k, w), {31'd0, bus.imem_req}, 32'd1);
        if (w == 2) begin
          check($sformatf("ws%0d instr", k), ifid_instruction, mem_word(32'h4 + 32'(4 * k)));
          check($sformatf("ws%0d pc", k), ifid_pc, 32'h8 + 32'(4 * k));
        end else begin
          check($sformatf("ws%0d.%0d bubble", k, w), ifid_pc, 32'h0);
        end
      end
    end

    // Randomized run against the instruction-stream model.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_next  = 32'h0;
    prev_hold = 1'b0;
    prev_addr = 32'h0;
    n_valid   = 0;
    for (int c = 0; c < 3000; c++) begin
      r_s   = ($urandom_range(0, 199) != 0);
      s_s   = ($urandom_range(0, 3) == 0);
      rd_s  = ($urandom_range(0, 19) == 0);
      rdy_s = ($urandom_range(0, 2) != 0);
      tgt_s = 32'($urandom_range(0, 4095));
      drive(r_s, s_s, rd_s, rdy_s, tgt_s);
      if (prev_hold && rst_n) begin
        check("rnd req held", {31'd0, bus.imem_req}, 32'd1);
        check("rnd addr held", bus.imem_addr, prev_addr);
      end
      if (!rst_n || redirect) begin
        check("rnd flush wren", {31'd0, ifid_wrenable}, 32'd1);
        check("rnd flush instr", ifid_instruction, 32'h0);
        check("rnd flush pc", ifid_pc, 32'h0);
        exp_next = rst_n ? {redirect_target[31:2], 2'b00} : 32'h0;
      end else if (stall) begin
        check("rnd stall wren", {31'd0, ifid_wrenable}, 32'd0);
      end else begin
        check("rnd run wren", {31'd0, ifid_wrenable}, 32'd1);
        if (ifid_pc != 32'h0) begin
          check("rnd stream pc", ifid_pc, exp_next + 32'd4);
          check("rnd stream instr", ifid_instruction, mem_word(exp_next));
          exp_next = exp_next + 32'd4;
          n_valid++;
        end else begin
          check("rnd bubble instr", ifid_instruction, 32'h0);
        end
      end
      prev_hold = rst_n & bus.imem_req & ~bus.imem_ready;
      prev_addr = bus.imem_addr;
    end
    check("rnd progress", {31'd0, (n_valid > 200)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
